// File: rtl/uart_rx_buffered.sv
// UART receiver with 3-sample mid-bit majority vote, optional parity, 1/2 stop bits,
// and a show-ahead FIFO carrying per-word parity/framing flags to a valid/ready consumer.
//
// state     | meaning
// ----------+-------------------------------------------------
// IDLE      | line idle, watching for a 1->0 edge on rxs
// START     | validating start bit (voted 1 = false start)
// DATA      | shifting in WIDTH data bits, LSB first
// PARITY    | checking the parity bit
// STOP      | sampling stop bit(s); push at last stop decision
// WAIT_IDLE | last stop bit was 0, wait for the line to go high
module uart_rx_buffered #(
    parameter int WIDTH      = 8,
    parameter int CLOCK_FREQ = 460800,
    parameter int BAUD_RATE  = 9600,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int DEPTH      = 4
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         rx,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic                         out_parity_error,
    output logic                         out_framing_error,
    output logic                         overrun,
    input  logic                         overrun_clear,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count
);
    localparam int T  = CLOCK_FREQ / BAUD_RATE;
    localparam int M  = T / 2;
    localparam int TW = $clog2(T);
    localparam int BW = $clog2(WIDTH + 1);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int EW = WIDTH + 2;

    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
    } state_t;

    state_t            state;
    logic              rx_meta, rxs, rxs_d;
    logic [TW-1:0]     tick;
    logic [BW-1:0]     bit_idx;
    logic [WIDTH-1:0]  shift;
    logic              par_acc, parity_err, framing_err;
    logic              samp_a, samp_b;
    logic              vote, decide, bit_end, last_stop, push;
    logic [EW-1:0]     push_word;

    always_ff @(posedge clock) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
            rxs_d   <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
            rxs_d   <= rxs;
        end
    end

    always_comb begin
        vote      = (samp_a & samp_b) | (samp_a & rxs) | (samp_b & rxs);
        decide    = (tick == TW'(M + 1));
        bit_end   = (tick == TW'(T - 1));
        last_stop = (bit_idx == BW'(STOP_BITS - 1));
        push      = (state == S_STOP) && decide && last_stop;
        push_word = {framing_err | ~vote, parity_err, shift};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            tick        <= '0;
            bit_idx     <= '0;
            shift       <= '0;
            par_acc     <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            samp_a      <= 1'b1;
            samp_b      <= 1'b1;
        end else begin
            if (state != S_IDLE && state != S_WAIT_IDLE) begin
                tick <= bit_end ? '0 : tick + TW'(1);
                if (tick == TW'(M - 1)) samp_a <= rxs;
                if (tick == TW'(M))     samp_b <= rxs;
            end
            case (state)
                S_IDLE: begin
                    // The edge cycle itself counts as tick 0.
                    if (rxs_d && !rxs) begin
                        state       <= S_START;
                        tick        <= TW'(1);
                        bit_idx     <= '0;
                        par_acc     <= 1'b0;
                        parity_err  <= 1'b0;
                        framing_err <= 1'b0;
                    end
                end
                S_START: begin
                    if (decide && vote) state <= S_IDLE;
                    else if (bit_end)   state <= S_DATA;
                end
                S_DATA: begin
                    if (decide) begin
                        shift   <= (shift >> 1) | (WIDTH'(vote) << (WIDTH - 1));
                        par_acc <= par_acc ^ vote;
                    end
                    if (bit_end) begin
                        if (bit_idx == BW'(WIDTH - 1)) begin
                            bit_idx <= '0;
                            state   <= (PARITY != 0) ? S_PARITY : S_STOP;
                        end else begin
                            bit_idx <= bit_idx + BW'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (decide)
                        parity_err <= (PARITY == 1) ? (par_acc ^ vote) : ~(par_acc ^ vote);
                    if (bit_end) state <= S_STOP;
                end
                S_STOP: begin
                    if (decide) begin
                        if (!vote) framing_err <= 1'b1;
                        if (last_stop) state <= vote ? S_IDLE : S_WAIT_IDLE;
                    end
                    if (bit_end && !last_stop) bit_idx <= bit_idx + BW'(1);
                end
                S_WAIT_IDLE: begin
                    if (rxs) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    logic [EW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          pop, full, wr_en, drop;
    logic [EW-1:0] head;

    always_comb begin
        pop   = out_valid && out_ready;
        full  = (count == CW'(DEPTH));
        // When full, a simultaneous pop frees the slot the write lands in.
        wr_en = push && (!full || pop);
        drop  = push && full && !pop;
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem[wr_ptr] <= push_word;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            overrun <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !pop)      count <= count + CW'(1);
            else if (pop && !wr_en) count <= count - CW'(1);
            if (drop)               overrun <= 1'b1;
            else if (overrun_clear) overrun <= 1'b0;
        end
    end

    always_comb begin
        head              = mem[rd_ptr];
        out_valid         = (count != '0);
        out_data          = out_valid ? head[WIDTH-1:0] : '0;
        out_parity_error  = out_valid & head[WIDTH];
        out_framing_error = out_valid & head[WIDTH+1];
        fifo_count        = count;
    end
endmodule
